alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 116 +++++++++++
 tb/tb_alu_exec_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage arithmetic block for a single-cycle 32-bit MIPS-style core.
//   Holds the ALU-control decoder, the 32-bit ALU with zero/negative flags,
//   a 2-bit registered status register read by branch/jump control, and the
//   two PC adders (PC+4 and branch target).
//
// Ports
//   clk        in   1   clock; status register updates on rising edge
//   rst_n      in   1   asynchronous active-low reset of status register
//   aluop      in   2   ALUOp from main control
//   funct      in   6   instruction bits [5:0]
//   a          in  32   ALU operand A
//   b          in  32   ALU operand B
//   stat_we    in   1   status register write enable
//   pc         in  32   current program counter
//   imm_sext   in  32   sign-extended immediate
//   alu_ctl    out  3   decoded operation code
//   result     out 32   ALU result (combinational)
//   zout       out  1   result == 0 (combinational)
//   nout       out  1   result[31] (combinational)
//   status     out  2   registered {N, Z}
//   pc_plus4   out 32   pc + 4
//   br_target  out 32   pc_plus4 + (imm_sext << 2)
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        stat_we,
    input  logic [31:0] pc,
    input  logic [31:0] imm_sext,
    output logic [2:0]  alu_ctl,
    output logic [31:0] result,
    output logic        zout,
    output logic        nout,
    output logic [1:0]  status,
    output logic [31:0] pc_plus4,
    output logic [31:0] br_target
);

    logic [2:0]  w_ctl;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_slt;
    logic [31:0] w_result;
    logic [1:0]  r_status;

    // ALU control decode
    always_comb begin
        w_ctl = 3'b010;
        case (aluop)
            2'b00: w_ctl = 3'b010;
            2'b01: w_ctl = 3'b110;
            2'b11: w_ctl = 3'b001;
            2'b10: begin
                case (funct)
                    6'b100000: w_ctl = 3'b010;
                    6'b100010: w_ctl = 3'b110;
                    6'b100100: w_ctl = 3'b000;
                    6'b100101: w_ctl = 3'b001;
                    6'b100111: w_ctl = 3'b100;
                    6'b100110: w_ctl = 3'b011;
                    6'b101010: w_ctl = 3'b111;
                    // jr/jalr and unknown functs fall back to ADD
                    default:   w_ctl = 3'b010;
                endcase
            end
            default: w_ctl = 3'b010;
        endcase
    end

    assign w_sum  = a + b;
    assign w_diff = a - b;

    // Signed less-than taken from the sign of the true 33-bit difference:
    // when the operand signs differ the 32-bit subtraction may overflow, but
    // then a < b exactly when a is the negative one.
    assign w_slt = (a[31] ^ b[31]) ? a[31] : w_diff[31];

    always_comb begin
        w_result = w_sum;
        case (w_ctl)
            3'b000:  w_result = a & b;
            3'b001:  w_result = a | b;
            3'b010:  w_result = w_sum;
            3'b110:  w_result = w_diff;
            3'b100:  w_result = ~(a | b);
            3'b011:  w_result = a ^ b;
            3'b111:  w_result = {31'd0, w_slt};
            default: w_result = w_sum;   // 101 is unused, behaves as ADD
        endcase
    end

    assign alu_ctl = w_ctl;
    assign result  = w_result;
    assign zout    = (w_result == 32'd0);
    assign nout    = w_result[31];

    // Status register: captures {N, Z}, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 2'b00;
        end else if (stat_we) begin
            r_status <= {w_result[31], (w_result == 32'd0)};
        end
    end

    assign status = r_status;

    // PC adders, both modulo 2^32; the top two immediate bits shift out
    assign pc_plus4  = pc + 32'h4;
    assign br_target = pc_plus4 + (imm_sext << 2);

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        stat_we;
    logic [31:0] pc;
    logic [31:0] imm_sext;
    logic [2:0]  alu_ctl;
    logic [31:0] result;
    logic        zout;
    logic        nout;
    logic [1:0]  status;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;

    alu_exec_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .aluop     (aluop),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .stat_we   (stat_we),
        .pc        (pc),
        .imm_sext  (imm_sext),
        .alu_ctl   (alu_ctl),
        .result    (result),
        .zout      (zout),
        .nout      (nout),
        .status    (status),
        .pc_plus4  (pc_plus4),
        .br_target (br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] res;
        logic        z;
        logic        n;
    } alu_exp_t;

    typedef struct {
        logic [31:0] p4;
        logic [31:0] bt;
    } pc_exp_t;

    alu_exp_t   alu_q[$];
    pc_exp_t    pc_q[$];
    logic [1:0] stat_q[$];
    alu_exp_t   last_exp;
    logic [1:0] held_stat;

    int n_tests;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model
    function automatic logic [2:0] m_ctl(input logic [1:0] op, input logic [5:0] fn);
        logic [2:0] c;
        if (op == 2'b00)      c = 3'b010;
        else if (op == 2'b01) c = 3'b110;
        else if (op == 2'b11) c = 3'b001;
        else begin
            case (fn)
                6'h20:   c = 3'b010;
                6'h22:   c = 3'b110;
                6'h24:   c = 3'b000;
                6'h25:   c = 3'b001;
                6'h27:   c = 3'b100;
                6'h26:   c = 3'b011;
                6'h2a:   c = 3'b111;
                default: c = 3'b010;
            endcase
        end
        return c;
    endfunction

    function automatic logic [31:0] m_res(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (c)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b110:  r = x - y;
            3'b100:  r = ~(x | y);
            3'b011:  r = x ^ y;
            3'b111:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = x + y;
        endcase
        return r;
    endfunction

    // Drive an ALU vector, push its expectation, then compare once settled
    task automatic apply(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] x, input logic [31:0] y, input string tag);
        alu_exp_t e;
        alu_exp_t g;
        aluop = op; funct = fn; a = x; b = y;
        e.ctl = m_ctl(op, fn);
        e.res = m_res(e.ctl, x, y);
        e.z   = (e.res == 32'd0);
        e.n   = e.res[31];
        alu_q.push_back(e);
        last_exp = e;
        #1;
        g = alu_q.pop_front();
        check_eq({tag, ".ctl"}, {29'd0, alu_ctl}, {29'd0, g.ctl});
        check_eq({tag, ".res"}, result, g.res);
        check_eq({tag, ".z"},   {31'd0, zout}, {31'd0, g.z});
        check_eq({tag, ".n"},   {31'd0, nout}, {31'd0, g.n});
    endtask

    task automatic apply_pc(input logic [31:0] p, input logic [31:0] imm, input string tag);
        pc_exp_t e;
        pc_exp_t g;
        pc = p; imm_sext = imm;
        e.p4 = p + 32'd4;
        e.bt = p + 32'd4 + {imm[29:0], 2'b00};
        pc_q.push_back(e);
        #1;
        g = pc_q.pop_front();
        check_eq({tag, ".p4"}, pc_plus4, g.p4);
        check_eq({tag, ".bt"}, br_target, g.bt);
    endtask

    // Clock the current flags into the status register and compare
    task automatic capture(input string tag);
        logic [1:0] g;
        stat_we = 1'b1;
        stat_q.push_back({last_exp.n, last_exp.z});
        @(posedge clk);
        #1;
        stat_we = 1'b0;
        g = stat_q.pop_front();
        held_stat = g;
        check_eq(tag, {30'd0, status}, {30'd0, g});
    endtask

    logic [5:0] fn_tab [0:9];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25;
        fn_tab[4] = 6'h27; fn_tab[5] = 6'h26; fn_tab[6] = 6'h2a; fn_tab[7] = 6'h08;
        fn_tab[8] = 6'h09; fn_tab[9] = 6'h00;

        rst_n = 1'b1; stat_we = 1'b0;
        aluop = 2'b00; funct = 6'd0; a = 32'd0; b = 32'd0;
        pc = 32'd0; imm_sext = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset.status", {30'd0, status}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type SUB, negative result, status capture 10
        @(negedge clk);
        apply(2'b10, 6'b100010, 32'd5, 32'd7, "rsub");
        check_eq("rsub.lit", result, 32'hFFFFFFFE);
        capture("rsub.status");
        check_eq("rsub.status.lit", {30'd0, status}, 32'd2);

        // SLT signed, including the overflowing case
        @(negedge clk);
        apply(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, "slt1");
        check_eq("slt1.lit", result, 32'd1);
        apply(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, "slt2");
        check_eq("slt2.lit", result, 32'd0);
        apply(2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, "slt3");
        check_eq("slt3.lit", result, 32'd1);
        apply(2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, "slt4");

        // Non-R-type decode
        apply(2'b00, 6'h3f, 32'hFFFFFFFF, 32'd1, "addwrap");
        check_eq("addwrap.lit", result, 32'd0);
        apply(2'b11, 6'h22, 32'hF0, 32'h0F, "ori");
        check_eq("ori.lit", result, 32'hFF);
        apply(2'b01, 6'h20, 32'h1234, 32'h1234, "beq");
        check_eq("beq.zlit", {31'd0, zout}, 32'd1);
        capture("beq.status");

        // Status holds with stat_we low while the flags change
        @(negedge clk);
        apply(2'b01, 6'h20, 32'd1, 32'd2, "hold");
        @(posedge clk);
        #1;
        check_eq("hold.status", {30'd0, status}, {30'd0, held_stat});

        // Logic ops and default decode
        @(negedge clk);
        apply(2'b10, 6'b100100, 32'hFFFF0000, 32'h0F0F0F0F, "and");
        check_eq("and.lit", result, 32'h0F0F0000);
        apply(2'b10, 6'b100101, 32'hFFFF0000, 32'h0F0F0F0F, "or");
        check_eq("or.lit", result, 32'hFFFF0F0F);
        apply(2'b10, 6'b100111, 32'hFFFF0000, 32'h0F0F0F0F, "nor");
        check_eq("nor.lit", result, 32'h0000F0F0);
        apply(2'b10, 6'b100110, 32'hFFFF0000, 32'h0F0F0F0F, "xor");
        check_eq("xor.lit", result, 32'hF0F00F0F);
        apply(2'b10, 6'b001000, 32'hFFFF0000, 32'h0F0F0F0F, "jr");
        check_eq("jr.ctl.lit", {29'd0, alu_ctl}, 32'd2);
        apply(2'b10, 6'b001001, 32'd3, 32'd4, "jalr");
        apply(2'b10, 6'b100000, 32'd3, 32'd4, "radd");

        // PC adders
        apply_pc(32'h00000010, 32'hFFFFFFFE, "pc1");
        check_eq("pc1.p4.lit", pc_plus4, 32'h14);
        check_eq("pc1.bt.lit", br_target, 32'h0C);
        apply_pc(32'hFFFFFFFC, 32'h00000001, "pc2");
        check_eq("pc2.p4.lit", pc_plus4, 32'h0);
        apply_pc(32'h00400000, 32'h40000003, "pc3");

        // Random vectors through the scoreboard
        for (int i = 0; i < 24; i++) begin
            apply(2'($urandom_range(0, 3)), fn_tab[$urandom_range(0, 9)],
                  $urandom, $urandom, "rand");
            apply_pc($urandom, $urandom, "randpc");
        end

        // Reset mid-cycle: status clears at once, datapath unaffected
        @(negedge clk);
        apply(2'b10, 6'b100010, 32'd5, 32'd7, "pre_rst");
        capture("pre_rst.status");
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst.status", {30'd0, status}, 32'd0);
        check_eq("async_rst.res", result, 32'hFFFFFFFE);
        stat_we = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_edge.status", {30'd0, status}, 32'd0);
        stat_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        capture("post_rst.status");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, limit 100000");
        $fatal(1, "timeout");
    end

endmodule
